rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one resource among N requesters, with registered one-hot grants.

---
 rtl/arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 37 +++
 rtl/rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_rr_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter family: FSM state encodings and a
// constant-evaluable ceiling-log2 helper used to size counters and indices.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_e;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: finds the first set request starting just after
// the previous winner and wrapping around. Purely combinational; the caller
// registers whatever it needs.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           any,
    output logic [IDW-1:0] win_id,
    output logic [N-1:0]   win_onehot
);

    logic found;

    // Search offsets 1..N from the last winner; the first hit wins, so the
    // last winner itself is considered only at offset N (lowest priority).
    always_comb begin
        any        = |req;
        win_id     = '0;
        win_onehot = '0;
        found      = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == ((int'(last) + k) % N))) begin
                    found         = 1'b1;
                    win_id        = IDW'(i);
                    win_onehot[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant. A grant is held until
// the owner drops its request, followed by one dead GAP cycle before the
// next grant. gnt drives the shared resource mux select directly.
// Optional hold limit: define ARB_TIMEOUT_EN to revoke a grant after
// MAX_HOLD consecutive cycles (timeout pulses during the following GAP).
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    // Reject configurations the search and counter sizing cannot support.
    if (N < 2 || N > 8 || IDW < clog2(N) || MAX_HOLD < 2) begin : g_param_check
        $error("rr_arbiter: illegal parameter combination");
    end

    // Pointer reset to N-1 so that requester 0 is searched first.
    localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic           busy_q, busy_d;
    logic [IDW-1:0] last_q, last_d;

    logic           pick_any;
    logic [IDW-1:0] pick_id;
    logic [N-1:0]   pick_onehot;
    logic           owner_req;
    logic           hold_lim;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req        (req),
        .last       (last_q),
        .any        (pick_any),
        .win_id     (pick_id),
        .win_onehot (pick_onehot)
    );

    // Owner's request, taken through the one-hot grant to avoid indexing.
    assign owner_req = |(req & gnt_q);

`ifdef ARB_TIMEOUT_EN
    localparam int HCW = (clog2(MAX_HOLD) < 1) ? 1 : clog2(MAX_HOLD);

    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           timeout_q, timeout_d;

    assign hold_lim = (hold_cnt_q == HCW'(MAX_HOLD - 1));

    // Count cycles spent with the same owner; any exit from GRANT clears it.
    always_comb begin
        hold_cnt_d = '0;
        if (state_q == ST_GRANT && state_d == ST_GRANT) begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
        end
        // A natural release on the limit edge is a release, not a timeout.
        timeout_d = (state_q == ST_GRANT) && owner_req && hold_lim;
    end

    // Hold counter and timeout pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign hold_lim = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Next-state logic: IDLE/GAP pick a new owner, GRANT waits for release.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        last_d   = last_q;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (pick_any) begin
                    state_d  = ST_GRANT;
                    gnt_d    = pick_onehot;
                    gnt_id_d = pick_id;
                    busy_d   = 1'b1;
                    last_d   = pick_id;
                end else begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    busy_d   = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!owner_req || hold_lim) begin
                    state_d = ST_GAP;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM, round-robin pointer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            last_q   <= LAST_RST;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4). Each step drives req, queues the
// outputs expected after the next rising edge, and checks them #1 later.
module tb_rr_arbiter;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    always #5 clk = ~clk;

    rr_arbiter #(
        .N        (N),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] id;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive req for the coming edge, queue the expectation, check after it.
    task automatic step(input logic [3:0] r, input logic [3:0] g, input logic b,
                        input logic [1:0] id, input logic t, input string tag);
        exp_t e;
        req    = r;
        e.tag  = tag;
        e.gnt  = g;
        e.busy = b;
        e.id   = id;
        e.to   = t;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".gnt"},     {4'b0, gnt},     {4'b0, e.gnt});
        check({e.tag, ".busy"},    {7'b0, busy},    {7'b0, e.busy});
        check({e.tag, ".timeout"}, {7'b0, timeout}, {7'b0, e.to});
        if (e.busy) begin
            check({e.tag, ".gnt_id"}, {6'b0, gnt_id}, {6'b0, e.id});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] oh;
        int         o;

        // Reset held with all requests pending: nothing granted.
        rst = 1'b0;
        req = 4'b1111;
        step(4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, "reset0");
        step(4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, "reset1");
        rst = 1'b1;
        step(4'b1111, 4'b0001, 1'b1, 2'd0, 1'b0, "rel_grant");

        // Rotation 0,1,2,3,0: three grant cycles, one-cycle drop, GAP.
        for (int i = 0; i < 5; i++) begin
            o  = i % 4;
            oh = 4'(1 << o);
            if (i > 0) step(4'b1111, oh, 1'b1, 2'(o), 1'b0, "rot_grant");
            step(4'b1111, oh, 1'b1, 2'(o), 1'b0, "rot_hold");
            step(4'b1111, oh, 1'b1, 2'(o), 1'b0, "rot_hold");
            step(4'b1111 & ~oh, 4'b0000, 1'b0, 2'd0, 1'b0, "rot_gap");
        end

        // Fairness between 0 and 2; last owner was 0, so 2 goes first.
        for (int i = 0; i < 4; i++) begin
            o  = (i % 2 == 0) ? 2 : 0;
            oh = 4'(1 << o);
            step(4'b0101, oh, 1'b1, 2'(o), 1'b0, "fair_grant");
            step(4'b0101 & ~oh, 4'b0000, 1'b0, 2'd0, 1'b0, "fair_gap");
        end
        step(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "fair_idle");

        // No preemption: req[0] rises while 1 owns the resource.
        step(4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0, "np_grant");
        for (int i = 0; i < 3; i++) step(4'b0011, 4'b0010, 1'b1, 2'd1, 1'b0, "np_hold");
        step(4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0, "np_gap");
        step(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "np_next");
        step(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "np_gap2");
        step(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "np_idle");

        // Hold limit with a single continuous requester.
        step(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "to_grant");
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "to_hold");
        step(4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1, "to_gap");
        step(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "to_regrant");
        for (int i = 0; i < MAX_HOLD - 1; i++) step(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "to_hold2");
        step(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "to_release_at_limit");
`else
        for (int i = 0; i < MAX_HOLD + 4; i++) step(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0, "hold_forever");
        step(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "hold_release");
`endif
        step(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, "to_idle");

        // Asynchronous reset while requester 2 owns the resource.
        step(4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0, "rm_grant");
        rst = 1'b0;
        #1;
        check("rm_async.gnt",  {4'b0, gnt},  8'h00);
        check("rm_async.busy", {7'b0, busy}, 8'h00);
        step(4'b0110, 4'b0000, 1'b0, 2'd0, 1'b0, "rm_in_reset");
        rst = 1'b1;
        step(4'b0110, 4'b0010, 1'b1, 2'd1, 1'b0, "rm_after");
        step(4'b0110, 4'b0010, 1'b1, 2'd1, 1'b0, "rm_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
